// File: rtl/rebuster_bus_arbiter.sv
// ---------------------------------------------------------------------------
// rebuster_bus_arbiter
//
// Bus arbiter for the Buster replacement. It collects Zorro expansion bus
// requests (EBR_n) and the DMAC request (SBR_n), obtains the 68030 bus with
// the BR/BG/BGACK handshake, and hands out exactly one grant at a time.
// The arbitration policy is either fixed priority or round-robin. A grant
// that is never acknowledged is withdrawn after a programmable number of
// CPU clock edges.
//
// The block runs on clk100. State only advances on cycles where the
// cpuclk_rising strobe from the top-level phase tracker is high.
//
// Parameters
//   NUM_SLOTS     number of Zorro request/grant pairs (1..8)
//   RR_MODE       0 = fixed priority (lowest index wins),
//                 1 = round-robin, starting after the last owner
//   GRANT_TIMEOUT cpuclk_rising strobes to wait for BGACK_n (1..255)
//   DMAC_FIRST    1 = SBR_n beats every Zorro slot,
//                 0 = DMAC takes part in the policy as slot NUM_SLOTS
//
// Ports
//   clk100         100 MHz clock, phase-locked to CPUCLK
//   reset          asynchronous, active-high reset
//   cpuclk_rising  one-cycle strobe that qualifies every state change
//   ebr_n_in       Zorro bus requests, active-low, asynchronous
//   sbr_n_in       DMAC bus request, active-low, asynchronous
//   bg_n_in        CPU bus grant, active-low
//   bgack_n_in     bus grant acknowledge seen on the pin, active-low
//   as_n_in        CPU address strobe, active-low
//   br_n_out       bus request to the CPU, active-low
//   br_n_oe        output enable for BR_n (always driven)
//   ebg_n_out      Zorro grants, active-low, at most one low
//   ebg_n_oe       output enables for the Zorro grants (always driven)
//   sbg_n_out      DMAC grant, active-low
//   sbg_n_oe       output enable for SBG_n (always driven)
//   owner          index of the granted/owning master, 4'hF when none
//   timeout_pulse  one clk100 cycle high when a grant is withdrawn
// ---------------------------------------------------------------------------
module rebuster_bus_arbiter #(
   parameter int NUM_SLOTS     = 5,
   parameter int RR_MODE       = 1,
   parameter int GRANT_TIMEOUT = 15,
   parameter int DMAC_FIRST    = 1
) (
   input  logic                 clk100,
   input  logic                 reset,
   input  logic                 cpuclk_rising,
   input  logic [NUM_SLOTS-1:0] ebr_n_in,
   input  logic                 sbr_n_in,
   input  logic                 bg_n_in,
   input  logic                 bgack_n_in,
   input  logic                 as_n_in,
   output logic                 br_n_out,
   output logic                 br_n_oe,
   output logic [NUM_SLOTS-1:0] ebg_n_out,
   output logic [NUM_SLOTS-1:0] ebg_n_oe,
   output logic                 sbg_n_out,
   output logic                 sbg_n_oe,
   output logic [3:0]           owner,
   output logic                 timeout_pulse
);

   // When the DMAC has absolute priority it sits outside the policy and the
   // round-robin pointer only walks the Zorro slots.
   localparam int         NUM_POLICY    = (DMAC_FIRST != 0) ? NUM_SLOTS : NUM_SLOTS + 1;
   localparam logic [3:0] DMAC_IDX      = 4'(NUM_SLOTS);
   localparam logic [3:0] NO_OWNER      = 4'hF;
   localparam logic [7:0] TIMEOUT_LIMIT = 8'(GRANT_TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      GRANT,
      OWNED
   } state_t;

   state_t                state_q, state_d;
   logic [3:0]            owner_q, owner_d;
   logic [3:0]            rr_ptr_q, rr_ptr_d;
   logic [7:0]            count_q, count_d;
   logic                  br_n_q, br_n_d;
   logic [NUM_SLOTS-1:0]  ebg_n_q, ebg_n_d;
   logic                  sbg_n_q, sbg_n_d;
   logic                  timeout_q, timeout_d;

   logic [NUM_SLOTS-1:0]  ebr_meta, ebr_sync;
   logic                  sbr_meta, sbr_sync;
   logic                  bg_meta, bg_sync;
   logic                  bgack_meta, bgack_sync;
   logic                  as_meta, as_sync;

   logic [15:0]           all_req;
   logic [15:0]           policy_req;
   logic                  any_req;
   logic                  owner_req;
   logic [3:0]            winner;
   logic [3:0]            ptr_after_owner;

   // Two-flop synchronisers for every asynchronous pin. They reset to the
   // inactive (high) level so nothing looks like a request coming out of
   // reset.
   always_ff @(posedge clk100 or posedge reset) begin
      if (reset) begin
         ebr_meta   <= '1;
         ebr_sync   <= '1;
         sbr_meta   <= 1'b1;
         sbr_sync   <= 1'b1;
         bg_meta    <= 1'b1;
         bg_sync    <= 1'b1;
         bgack_meta <= 1'b1;
         bgack_sync <= 1'b1;
         as_meta    <= 1'b1;
         as_sync    <= 1'b1;
      end else begin
         ebr_meta   <= ebr_n_in;
         ebr_sync   <= ebr_meta;
         sbr_meta   <= sbr_n_in;
         sbr_sync   <= sbr_meta;
         bg_meta    <= bg_n_in;
         bg_sync    <= bg_meta;
         bgack_meta <= bgack_n_in;
         bgack_sync <= bgack_meta;
         as_meta    <= as_n_in;
         as_sync    <= as_meta;
      end
   end

   // Active-high request vector indexed by master number: Zorro slots in
   // the low bits and the DMAC at index NUM_SLOTS. The policy vector drops
   // the DMAC when it is handled ahead of the policy.
   always_comb begin
      all_req = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         all_req[i] = ~ebr_sync[i];
      end
      all_req[NUM_SLOTS] = ~sbr_sync;

      policy_req = all_req;
      if (DMAC_FIRST != 0) begin
         policy_req[NUM_SLOTS] = 1'b0;
      end

      any_req   = |all_req;
      owner_req = all_req[owner_q];
   end

   // Winner selection. Round-robin scans forward from rr_ptr and wraps past
   // the top policy index; fixed priority simply takes the lowest index.
   always_comb begin
      logic       found;
      logic [4:0] scan_idx;
      winner   = NO_OWNER;
      found    = 1'b0;
      scan_idx = '0;
      if ((DMAC_FIRST != 0) && !sbr_sync) begin
         winner = DMAC_IDX;
      end else if (RR_MODE == 0) begin
         for (int i = 0; i < NUM_POLICY; i++) begin
            if (!found && policy_req[i[3:0]]) begin
               winner = i[3:0];
               found  = 1'b1;
            end
         end
      end else begin
         for (int k = 0; k < NUM_POLICY; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + 5'(k);
            if (scan_idx >= 5'(NUM_POLICY)) begin
               scan_idx = scan_idx - 5'(NUM_POLICY);
            end
            if (!found && policy_req[scan_idx[3:0]]) begin
               winner = scan_idx[3:0];
               found  = 1'b1;
            end
         end
      end
   end

   // Slot following the master that just released the bus, folded back
   // into the policy range.
   always_comb begin
      logic [4:0] next_idx;
      next_idx = {1'b0, owner_q} + 5'd1;
      if (next_idx >= 5'(NUM_POLICY)) begin
         next_idx = next_idx - 5'(NUM_POLICY);
      end
      ptr_after_owner = next_idx[3:0];
   end

   // State register. All outputs are registered here so that an incoming
   // reset drops every grant and BR_n at once, without waiting for a clock.
   always_ff @(posedge clk100 or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         owner_q   <= NO_OWNER;
         rr_ptr_q  <= '0;
         count_q   <= '0;
         br_n_q    <= 1'b1;
         ebg_n_q   <= '1;
         sbg_n_q   <= 1'b1;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         rr_ptr_q  <= rr_ptr_d;
         count_q   <= count_d;
         br_n_q    <= br_n_d;
         ebg_n_q   <= ebg_n_d;
         sbg_n_q   <= sbg_n_d;
         timeout_q <= timeout_d;
      end
   end

   // Next-state logic. The winner is latched once in IDLE and never
   // re-evaluated until the next IDLE, so requests arriving later simply
   // stay pending. In GRANT the acknowledge is tested before the timeout so
   // a BGACK_n arriving on the timeout strobe still takes the bus.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      rr_ptr_d  = rr_ptr_q;
      count_d   = count_q;
      br_n_d    = br_n_q;
      ebg_n_d   = ebg_n_q;
      sbg_n_d   = sbg_n_q;
      timeout_d = 1'b0;

      if (cpuclk_rising) begin
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  owner_d = winner;
                  br_n_d  = 1'b0;
                  state_d = REQ;
               end
            end

            REQ: begin
               if (!owner_req) begin
                  br_n_d  = 1'b1;
                  owner_d = NO_OWNER;
                  state_d = IDLE;
               end else if (!bg_sync && as_sync && bgack_sync) begin
                  for (int i = 0; i < NUM_SLOTS; i++) begin
                     ebg_n_d[i] = (owner_q != 4'(i));
                  end
                  sbg_n_d = (owner_q != DMAC_IDX);
                  count_d = '0;
                  state_d = GRANT;
               end
            end

            GRANT: begin
               if (!bgack_sync) begin
                  ebg_n_d = '1;
                  sbg_n_d = 1'b1;
                  br_n_d  = 1'b1;
                  state_d = OWNED;
               end else if ((count_q + 8'd1) >= TIMEOUT_LIMIT) begin
                  ebg_n_d   = '1;
                  sbg_n_d   = 1'b1;
                  br_n_d    = 1'b1;
                  timeout_d = 1'b1;
                  owner_d   = NO_OWNER;
                  count_d   = count_q + 8'd1;
                  state_d   = IDLE;
               end else begin
                  count_d = count_q + 8'd1;
               end
            end

            OWNED: begin
               if (bgack_sync) begin
                  owner_d = NO_OWNER;
                  state_d = IDLE;
                  if (RR_MODE != 0) begin
                     rr_ptr_d = ptr_after_owner;
                  end
               end
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Outputs are always driven, so the enables are tied active.
   assign br_n_out      = br_n_q;
   assign br_n_oe       = 1'b1;
   assign ebg_n_out     = ebg_n_q;
   assign ebg_n_oe      = '1;
   assign sbg_n_out     = sbg_n_q;
   assign sbg_n_oe      = 1'b1;
   assign owner         = owner_q;
   assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_rebuster_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rebuster_bus_arbiter
//
// Directed bench for rebuster_bus_arbiter. Two instances share the same
// pins: "dut" with the default round-robin setup and "dut_fp" with fixed
// priority. The CPU clock strobe is one clk100 cycle in four. Inputs are
// changed just after a strobe has been consumed so they are through the
// synchronisers before the next strobe.
// ---------------------------------------------------------------------------
module tb_rebuster_bus_arbiter;

   logic       clk100 = 1'b0;
   logic       reset  = 1'b1;
   logic [1:0] phase  = 2'd0;
   logic       cpuclk_rising;

   logic [4:0] ebr_n;
   logic       sbr_n;
   logic       bg_n;
   logic       bgack_n;
   logic       as_n;

   logic       br_n, br_oe, sbg_n, sbg_oe, tmo;
   logic [4:0] ebg_n, ebg_oe;
   logic [3:0] owner;

   logic       br_n_fp, br_oe_fp, sbg_n_fp, sbg_oe_fp, tmo_fp;
   logic [4:0] ebg_n_fp, ebg_oe_fp;
   logic [3:0] owner_fp;

   int errors = 0;
   int checks = 0;

   int         rr_order [4] = '{0, 3, 0, 3};
   logic [4:0] exp_grant;

   always #5 clk100 = ~clk100;

   // Free-running CPU clock phase tracker: strobe on every fourth cycle.
   always @(posedge clk100) phase <= phase + 2'd1;
   assign cpuclk_rising = (phase == 2'd3);

   rebuster_bus_arbiter dut (
      .clk100        (clk100),
      .reset         (reset),
      .cpuclk_rising (cpuclk_rising),
      .ebr_n_in      (ebr_n),
      .sbr_n_in      (sbr_n),
      .bg_n_in       (bg_n),
      .bgack_n_in    (bgack_n),
      .as_n_in       (as_n),
      .br_n_out      (br_n),
      .br_n_oe       (br_oe),
      .ebg_n_out     (ebg_n),
      .ebg_n_oe      (ebg_oe),
      .sbg_n_out     (sbg_n),
      .sbg_n_oe      (sbg_oe),
      .owner         (owner),
      .timeout_pulse (tmo)
   );

   rebuster_bus_arbiter #(.RR_MODE(0)) dut_fp (
      .clk100        (clk100),
      .reset         (reset),
      .cpuclk_rising (cpuclk_rising),
      .ebr_n_in      (ebr_n),
      .sbr_n_in      (sbr_n),
      .bg_n_in       (bg_n),
      .bgack_n_in    (bgack_n),
      .as_n_in       (as_n),
      .br_n_out      (br_n_fp),
      .br_n_oe       (br_oe_fp),
      .ebg_n_out     (ebg_n_fp),
      .ebg_n_oe      (ebg_oe_fp),
      .sbg_n_out     (sbg_n_fp),
      .sbg_n_oe      (sbg_oe_fp),
      .owner         (owner_fp),
      .timeout_pulse (tmo_fp)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [4:0] ebr, input logic sbr, input logic bg,
                                input logic bgack, input logic as_v);
      ebr_n   = ebr;
      sbr_n   = sbr;
      bg_n    = bg;
      bgack_n = bgack;
      as_n    = as_v;
   endtask

   // Advance to the negedge just after the next strobe has been consumed.
   task automatic waitStrobe();
      int budget = 0;
      @(negedge clk100);
      while (!cpuclk_rising && budget < 16) begin
         @(negedge clk100);
         budget++;
      end
      if (!cpuclk_rising) begin
         checks++;
         errors++;
         $error("[TB] FAIL strobe_wait observed=no_strobe expected=strobe");
      end
      @(negedge clk100);
   endtask

   initial begin
      #200us;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      $display("[TB] start");
      applyStimulus(5'h1F, 1'b1, 1'b1, 1'b1, 1'b1);
      repeat (3) @(negedge clk100);

      // Reset state
      checkOutput("rst_br", 32'(br_n), 32'h1);
      checkOutput("rst_ebg", 32'(ebg_n), 32'h1F);
      checkOutput("rst_sbg", 32'(sbg_n), 32'h1);
      checkOutput("rst_owner", 32'(owner), 32'hF);
      checkOutput("rst_tmo", 32'(tmo), 32'h0);
      checkOutput("rst_oe", 32'({br_oe, ebg_oe, sbg_oe}), 32'h7F);
      reset = 1'b0;
      waitStrobe();

      // Round-robin fairness with slots 0 and 3 requesting continuously.
      // The fixed-priority instance keeps picking slot 0.
      applyStimulus(5'b10110, 1'b1, 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 4; k++) begin
         waitStrobe();
         checkOutput($sformatf("rr%0d_owner", k), 32'(owner), 32'(rr_order[k]));
         checkOutput($sformatf("rr%0d_fp_owner", k), 32'(owner_fp), 32'h0);
         checkOutput($sformatf("rr%0d_br", k), 32'(br_n), 32'h0);
         bg_n = 1'b0;
         waitStrobe();
         exp_grant = 5'h1F;
         exp_grant[rr_order[k]] = 1'b0;
         checkOutput($sformatf("rr%0d_ebg", k), 32'(ebg_n), 32'(exp_grant));
         checkOutput($sformatf("rr%0d_fp_ebg", k), 32'(ebg_n_fp), 32'h1E);
         bgack_n = 1'b0;
         waitStrobe();
         checkOutput($sformatf("rr%0d_ack_ebg", k), 32'(ebg_n), 32'h1F);
         checkOutput($sformatf("rr%0d_ack_br", k), 32'(br_n), 32'h1);
         bg_n    = 1'b1;
         bgack_n = 1'b1;
         waitStrobe();
         checkOutput($sformatf("rr%0d_rel_owner", k), 32'(owner), 32'hF);
      end
      ebr_n = 5'h1F;
      waitStrobe();
      checkOutput("idle_owner", 32'(owner), 32'hF);
      checkOutput("idle_br", 32'(br_n), 32'h1);

      // Single requester on slot 2; the CPU grants three strobes later.
      applyStimulus(5'b11011, 1'b1, 1'b1, 1'b1, 1'b1);
      waitStrobe();
      checkOutput("single_br", 32'(br_n), 32'h0);
      checkOutput("single_owner", 32'(owner), 32'h2);
      checkOutput("single_fp_owner", 32'(owner_fp), 32'h2);
      waitStrobe();
      waitStrobe();
      checkOutput("single_wait_ebg", 32'(ebg_n), 32'h1F);
      bg_n = 1'b0;
      waitStrobe();
      checkOutput("single_ebg", 32'(ebg_n), 32'b11011);
      checkOutput("single_fp_ebg", 32'(ebg_n_fp), 32'b11011);
      applyStimulus(5'h1F, 1'b1, 1'b0, 1'b0, 1'b1);
      waitStrobe();
      checkOutput("single_ack_ebg", 32'(ebg_n), 32'h1F);
      checkOutput("single_ack_br", 32'(br_n), 32'h1);
      checkOutput("single_ack_owner", 32'(owner), 32'h2);
      bg_n    = 1'b1;
      bgack_n = 1'b1;
      waitStrobe();
      checkOutput("single_rel_owner", 32'(owner), 32'hF);

      // DMAC and slot 1 together: the DMAC wins.
      applyStimulus(5'b11101, 1'b0, 1'b1, 1'b1, 1'b1);
      waitStrobe();
      checkOutput("dmac_owner", 32'(owner), 32'h5);
      checkOutput("dmac_fp_owner", 32'(owner_fp), 32'h5);
      bg_n = 1'b0;
      waitStrobe();
      checkOutput("dmac_sbg", 32'(sbg_n), 32'h0);
      checkOutput("dmac_ebg", 32'(ebg_n), 32'h1F);
      checkOutput("dmac_fp_sbg", 32'(sbg_n_fp), 32'h0);
      applyStimulus(5'h1F, 1'b1, 1'b0, 1'b0, 1'b1);
      waitStrobe();
      checkOutput("dmac_ack_sbg", 32'(sbg_n), 32'h1);
      bg_n    = 1'b1;
      bgack_n = 1'b1;
      waitStrobe();
      checkOutput("dmac_rel_owner", 32'(owner), 32'hF);

      // Timeout: slot 4 granted but never acknowledged, slot 0 pending.
      applyStimulus(5'b01111, 1'b1, 1'b1, 1'b1, 1'b1);
      waitStrobe();
      checkOutput("tmo_owner", 32'(owner), 32'h4);
      bg_n = 1'b0;
      waitStrobe();
      checkOutput("tmo_ebg", 32'(ebg_n), 32'b01111);
      ebr_n = 5'b01110;
      repeat (14) waitStrobe();
      checkOutput("tmo_14_ebg", 32'(ebg_n), 32'b01111);
      checkOutput("tmo_14_pulse", 32'(tmo), 32'h0);
      waitStrobe();
      checkOutput("tmo_15_ebg", 32'(ebg_n), 32'h1F);
      checkOutput("tmo_15_pulse", 32'(tmo), 32'h1);
      checkOutput("tmo_15_owner", 32'(owner), 32'hF);
      checkOutput("tmo_15_br", 32'(br_n), 32'h1);
      checkOutput("tmo_15_fp_pulse", 32'(tmo_fp), 32'h1);
      @(negedge clk100);
      checkOutput("tmo_pulse_end", 32'(tmo), 32'h0);
      ebr_n = 5'b11110;
      waitStrobe();
      checkOutput("tmo_next_owner", 32'(owner), 32'h0);
      waitStrobe();
      checkOutput("tmo_next_ebg", 32'(ebg_n), 32'b11110);
      applyStimulus(5'h1F, 1'b1, 1'b0, 1'b0, 1'b1);
      waitStrobe();
      bg_n    = 1'b1;
      bgack_n = 1'b1;
      waitStrobe();
      checkOutput("tmo_rel_owner", 32'(owner), 32'hF);

      // Bus busy: BG_n low while AS_n is still low for four strobes.
      applyStimulus(5'b11101, 1'b1, 1'b1, 1'b1, 1'b1);
      waitStrobe();
      checkOutput("busy_owner", 32'(owner), 32'h1);
      applyStimulus(5'b11101, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) begin
         waitStrobe();
         checkOutput($sformatf("busy%0d_ebg", k), 32'(ebg_n), 32'h1F);
      end
      as_n = 1'b1;
      waitStrobe();
      checkOutput("busy_grant_ebg", 32'(ebg_n), 32'b11101);
      applyStimulus(5'h1F, 1'b1, 1'b0, 1'b0, 1'b1);
      waitStrobe();
      bg_n    = 1'b1;
      bgack_n = 1'b1;
      waitStrobe();
      checkOutput("busy_rel_owner", 32'(owner), 32'hF);

      // Reset while slot 2 holds a grant.
      applyStimulus(5'b11011, 1'b1, 1'b1, 1'b1, 1'b1);
      waitStrobe();
      bg_n = 1'b0;
      waitStrobe();
      checkOutput("mid_ebg", 32'(ebg_n), 32'b11011);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("mid_rst_ebg", 32'(ebg_n), 32'h1F);
      checkOutput("mid_rst_br", 32'(br_n), 32'h1);
      checkOutput("mid_rst_owner", 32'(owner), 32'hF);
      checkOutput("mid_rst_fp_ebg", 32'(ebg_n_fp), 32'h1F);
      applyStimulus(5'h1F, 1'b1, 1'b1, 1'b1, 1'b1);
      @(negedge clk100);
      reset = 1'b0;
      waitStrobe();
      waitStrobe();
      checkOutput("post_rst_owner", 32'(owner), 32'hF);
      checkOutput("post_rst_br", 32'(br_n), 32'h1);
      ebr_n = 5'b10111;
      waitStrobe();
      checkOutput("post_rst_req_owner", 32'(owner), 32'h3);
      checkOutput("post_rst_req_br", 32'(br_n), 32'h0);

      // Requester gives up while waiting for the CPU.
      ebr_n = 5'h1F;
      waitStrobe();
      checkOutput("withdraw_owner", 32'(owner), 32'hF);
      checkOutput("withdraw_br", 32'(br_n), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rebuster_bus_arbiter.md
Name: rebuster_bus_arbiter

Overview:
- Parametrised bus arbiter for the Buster replacement. It collects Zorro expansion requests (EBR_n) and the DMAC request (SBR_n), obtains the 68030 bus through BR/BG/BGACK, and issues exactly one grant at a time.
- Generalises the fixed 5-slot arbitration to N slots, with selectable fixed-priority or round-robin policy and a grant-timeout recovery path.
- Runs on clk100; all decisions are qualified by the cpuclk_rising strobe from the top-level phase tracker.

Parameters:
- NUM_SLOTS, 5, number of Zorro request/grant pairs (1..8).
- RR_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin starting after the last granted slot.
- GRANT_TIMEOUT, 15, cpuclk_rising strobes to wait for BGACK_n after a grant before withdrawing it (1..255).
- DMAC_FIRST, 1, 1 = SBR_n beats every Zorro slot, 0 = DMAC is treated as slot index NUM_SLOTS in the policy.

Ports:
- clk100 in 1: 100 MHz clock, phase-locked to CPUCLK.
- reset in 1: asynchronous, active-high reset.
- cpuclk_rising in 1: one-cycle strobe. All state advances only on cycles where this is high.
- ebr_n_in in NUM_SLOTS: Zorro bus requests, active-low, asynchronous.
- sbr_n_in in 1: DMAC bus request, active-low, asynchronous.
- bg_n_in in 1: CPU bus grant, active-low.
- bgack_n_in in 1: bus grant acknowledge as seen on the pin, active-low.
- as_n_in in 1: CPU address strobe, active-low.
- br_n_out out 1: bus request to the CPU, active-low.
- br_n_oe out 1: output enable for BR_n.
- ebg_n_out out NUM_SLOTS: Zorro grants, active-low, one-hot-low.
- ebg_n_oe out NUM_SLOTS: output enables for the Zorro grants.
- sbg_n_out out 1: DMAC grant, active-low.
- sbg_n_oe out 1: output enable for SBG_n.
- owner out 4: index of the granted or owning master; 4'hF when there is none.
- timeout_pulse out 1: one clk100 cycle high when a grant is withdrawn by timeout.

Behaviour:
- Synchronisation: ebr_n_in, sbr_n_in, bg_n_in, bgack_n_in and as_n_in each pass through a 2-flop synchroniser on clk100 (reset value 1). All logic uses the synchronised values.
- Reset values:
  - br_n_out = 1, all ebg_n_out = 1, sbg_n_out = 1.
  - All *_oe = 1 (outputs are always driven).
  - owner = 4'hF, timeout_pulse = 0, state = IDLE, rr_ptr = 0, timeout counter = 0.
- A reset that arrives mid-operation immediately deasserts every grant and BR_n. No partial handshake survives reset.
- States, each transition evaluated on a cpuclk_rising cycle:
  - IDLE: when any request is low, latch the winner under the selected policy into owner and drive br_n_out = 0. Go to REQ.
  - REQ: wait for bg_n = 0, as_n = 1 and bgack_n = 1 (CPU has released the bus, no prior owner remains). Then drive the winner's grant low, clear the counter and go to GRANT. The winner is not re-evaluated in REQ.
  - REQ, request withdrawn: if the winner's request goes high while in REQ, drop BR_n, set owner = F and return to IDLE.
  - GRANT: when bgack_n = 0, deassert the grant and BR_n, then go to OWNED. Otherwise increment the counter. When the counter reaches GRANT_TIMEOUT, deassert the grant and BR_n, pulse timeout_pulse, set owner = F and go to IDLE.
  - OWNED: when bgack_n = 1, set owner = F and go to IDLE. If RR_MODE = 1, rr_ptr becomes the slot after the last owner, modulo the number of policy slots.
- Fixed priority: the lowest index wins. Round-robin: the first requesting index at or after rr_ptr wins, wrapping past the top index.
- DMAC_FIRST = 1: sbr_n = 0 overrides every Zorro request in IDLE. It never pre-empts a grant already given.
- Simultaneous events:
  - Requests arriving while in REQ, GRANT or OWNED are held pending until the next IDLE.
  - bgack_n low at the same strobe as the timeout: acknowledge wins, and the block goes to OWNED.
- At most one of ebg_n_out/sbg_n_out is low at any time.
- Grant latency: a grant is driven on the first strobe where the REQ conditions hold.
- Latency from a request pin edge to BR_n low: at most 2 clk100 synchroniser cycles plus 1 strobe plus 1 cycle.

Test Plan:
- Single requester: RR_MODE = 0, ebr_n_in = 5'b11011. Bench drops bg_n after 3 strobes. Required: br_n = 0, then ebg_n_out = 5'b11011 with owner = 2. After bgack_n is driven low: ebg_n = 1F and br_n = 1. After bgack_n goes high: owner = F.
- Round-robin fairness: RR_MODE = 1, slots 0 and 3 requesting continuously, full handshakes performed. Required: grant order 0, 3, 0, 3.
- DMAC override: sbr_n = 0 and ebr_n[1] = 0 together in IDLE with DMAC_FIRST = 1. Required: sbg_n = 0, ebg_n untouched, owner = 5.
- Timeout: grant slot 4 and never assert bgack_n. Required: after exactly 15 strobes, ebg_n[4] returns to 1, timeout_pulse is high for 1 cycle, and a pending slot 0 is granted next.
- Bus busy: bg_n = 0 while as_n = 0 for 4 strobes. Required: no grant until the strobe after as_n goes high.
- Reset mid-GRANT: assert reset while ebg_n[2] = 0. Required: all grants = 1, br_n = 1, owner = F in the same cycle; after release, state is IDLE.
